// File: rtl/regfile_pkg.sv
// Shared FSM encoding and constants for the parameterised register file.
package regfile_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    DUMP = 2'd2
  } state_e;

  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_bypass.sv
// Per-port read mux: forced zero, hardwired register 0, write-through bypass.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          force_zero,
  input  logic [AW-1:0] rr,
  input  logic [DW-1:0] stored,
  input  logic          we,
  input  logic [AW-1:0] wr,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] rd
);

  always_comb begin
    rd = stored;
    if (force_zero || rr == AW'(ZERO_REG)) begin
      rd = '0;
    end else if (we && wr != AW'(ZERO_REG) && wr == rr) begin
      rd = wd;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// Register file with power-up zeroing sweep, bypassed reads, an observation
// port and a ready/valid stream that dumps every register in index order.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned OBS_IDX = 1
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic [AW-1:0] rr1,
  input  logic [AW-1:0] rr2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic [AW-1:0] wr,
  input  logic [DW-1:0] wd,
  input  logic          reg_write,
  output logic [DW-1:0] obs_data,
  output logic          busy,
  input  logic          dump_req,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [AW-1:0] dump_idx,
  output logic [DW-1:0] dump_data
);

  localparam int unsigned   NREG     = 2 ** AW;
  localparam logic [AW-1:0] LAST     = '1;
  localparam logic [AW-1:0] OBS_ADDR = AW'(OBS_IDX);

  logic [DW-1:0] mem [NREG];

  state_e        state_q, state_d;
  logic [AW-1:0] sweep_q, sweep_d;
  logic [AW-1:0] didx_q, didx_d;
  logic          we_eff;

  assign busy       = (state_q == INIT);
  assign dump_valid = (state_q == DUMP);
  assign dump_idx   = didx_q;
  assign we_eff     = reg_write & ~busy;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= INIT;
      sweep_q <= AW'(1);
      didx_q  <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      didx_q  <= didx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    didx_d  = didx_q;
    case (state_q)
      INIT: begin
        sweep_d = sweep_q + AW'(1);
        if (sweep_q == LAST) state_d = IDLE;
      end
      IDLE: begin
        if (dump_req) begin
          state_d = DUMP;
          didx_d  = '0;
        end
      end
      DUMP: begin
        if (dump_ready) begin
          if (didx_q == LAST) state_d = IDLE;
          else                didx_d  = didx_q + AW'(1);
        end
      end
      default: state_d = INIT;
    endcase
  end

  // The sweep owns the write port while busy; register 0 is never stored.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[sweep_q] <= '0;
    end else if (reg_write && wr != AW'(ZERO_REG)) begin
      mem[wr] <= wd;
    end
  end

  regfile_bypass #(.DW(DW), .AW(AW)) u_rd1 (
    .force_zero (busy),
    .rr         (rr1),
    .stored     (mem[rr1]),
    .we         (we_eff),
    .wr         (wr),
    .wd         (wd),
    .rd         (rd1)
  );

  regfile_bypass #(.DW(DW), .AW(AW)) u_rd2 (
    .force_zero (busy),
    .rr         (rr2),
    .stored     (mem[rr2]),
    .we         (we_eff),
    .wr         (wr),
    .wd         (wd),
    .rd         (rd2)
  );

  regfile_bypass #(.DW(DW), .AW(AW)) u_obs (
    .force_zero (busy),
    .rr         (OBS_ADDR),
    .stored     (mem[OBS_ADDR]),
    .we         (we_eff),
    .wr         (wr),
    .wd         (wd),
    .rd         (obs_data)
  );

  // Dump data is zero outside DUMP, which also covers the reset value.
  regfile_bypass #(.DW(DW), .AW(AW)) u_dump (
    .force_zero (state_q != DUMP),
    .rr         (didx_q),
    .stored     (mem[didx_q]),
    .we         (we_eff),
    .wr         (wr),
    .wd         (wd),
    .rd         (dump_data)
  );

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param with a scoreboard queue for the dump stream.
module tb_regfile_param;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NREG = 2 ** AW;

  logic          clk = 1'b0;
  logic          clr_n;
  logic [AW-1:0] rr1, rr2, wr, dump_idx;
  logic [DW-1:0] rd1, rd2, wd, obs_data, dump_data;
  logic          reg_write, busy, dump_req, dump_valid, dump_ready;

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } dump_t;

  dump_t         sb[$];
  dump_t         e;
  logic [DW-1:0] model [NREG];
  int            total = 0;
  int            passed = 0;
  int            cnt;
  int            k;
  logic          rdy;

  regfile_param #(.DW(DW), .AW(AW), .OBS_IDX(1)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .rr1        (rr1),
    .rr2        (rr2),
    .rd1        (rd1),
    .rd2        (rd2),
    .wr         (wr),
    .wd         (wd),
    .reg_write  (reg_write),
    .obs_data   (obs_data),
    .busy       (busy),
    .dump_req   (dump_req),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump();
    for (int unsigned i = 0; i < NREG; i++) begin
      e.idx  = AW'(i);
      e.data = model[i];
      sb.push_back(e);
    end
  endtask

  initial begin
    clr_n = 1'b0; rr1 = '0; rr2 = '0; wr = '0; wd = '0;
    reg_write = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) model[i] = '0;

    // Reset state
    next_cycle();
    next_cycle();
    check("rst_busy", busy, 1);
    check("rst_dump_valid", dump_valid, 0);
    check("rst_dump_idx", dump_idx, 0);
    check("rst_dump_data", dump_data, 0);

    // Sweep: writes attempted during busy must be ignored and reads stay 0
    clr_n = 1'b1;
    reg_write = 1'b1; wr = AW'(1); wd = 32'h55; rr1 = AW'(1);
    cnt = 0;
    while (busy && cnt < 100) begin
      check("sweep_rd1", rd1, 0);
      check("sweep_obs", obs_data, 0);
      next_cycle();
      cnt++;
    end
    check("sweep_len", cnt, 31);
    reg_write = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      rr1 = AW'(i); rr2 = AW'(i);
      #1;
      check("zero_rd1", rd1, 0);
      check("zero_rd2", rd2, 0);
    end

    // Write/read
    reg_write = 1'b1; wr = AW'(1); wd = 32'd70;  next_cycle(); model[1] = 32'd70;
    wr = AW'(2); wd = 32'd101; next_cycle(); model[2] = 32'd101;
    wr = AW'(3); wd = 32'd343; next_cycle(); model[3] = 32'd343;
    reg_write = 1'b0; rr1 = AW'(2); rr2 = AW'(3);
    #1;
    check("wr_rd1", rd1, model[2]);
    check("wr_rd2", rd2, model[3]);
    check("wr_obs", obs_data, model[1]);

    // Bypass on rd1 and obs_data
    next_cycle();
    reg_write = 1'b1; wr = AW'(5); wd = 32'hDEAD; rr1 = AW'(5);
    #1;
    check("byp_rd1", rd1, 32'hDEAD);
    check("byp_obs_other", obs_data, model[1]);
    next_cycle(); model[5] = 32'hDEAD;
    wr = AW'(1); wd = 32'h1234;
    #1;
    check("byp_obs", obs_data, 32'h1234);
    next_cycle(); model[1] = 32'h1234;

    // Register 0 discards writes
    wr = AW'(0); wd = 32'hFFFF; rr1 = AW'(0);
    #1;
    check("r0_same", rd1, 0);
    check("r0_obs", obs_data, model[1]);
    next_cycle();
    reg_write = 1'b0; rr2 = AW'(5);
    #1;
    check("r0_after", rd1, 0);
    check("r0_obs_after", obs_data, model[1]);
    check("r5_hold", rd2, model[5]);

    // Fill upper registers
    reg_write = 1'b1;
    for (int unsigned i = 8; i < NREG; i++) begin
      wr = AW'(i); wd = $urandom;
      next_cycle();
      model[i] = wd;
    end
    reg_write = 1'b0;

    // Dump with toggling ready; r7 rewritten in the first DUMP cycle
    model[7] = 32'd9;
    push_dump();
    dump_req = 1'b1;
    next_cycle();
    dump_req = 1'b0;
    k = 0; rdy = 1'b1;
    while (sb.size() > 0 && k < 200) begin
      reg_write = (k == 0); wr = AW'(7); wd = 32'd9;
      dump_ready = rdy;
      #2;
      check("dump_valid_hi", dump_valid, 1);
      if (dump_ready) begin
        e = sb.pop_front();
        check("dump_idx", dump_idx, e.idx);
        check("dump_data", dump_data, e.data);
      end else begin
        check("dump_hold_idx", dump_idx, sb[0].idx);
      end
      next_cycle();
      rdy = ~rdy;
      k++;
    end
    check("dump_remaining", sb.size(), 0);
    reg_write = 1'b0; dump_ready = 1'b0;
    check("dump_end_valid", dump_valid, 0);
    check("dump_end_busy", busy, 0);
    rr1 = AW'(7);
    #1;
    check("r7_after", rd1, 32'd9);

    // Abort dump at index 10 with reset, then dump_req during INIT
    next_cycle();
    push_dump();
    dump_req = 1'b1;
    next_cycle();
    dump_req = 1'b0; dump_ready = 1'b1;
    k = 0;
    while (dump_idx != AW'(10) && k < 50) begin
      #2;
      if (dump_valid) begin
        e = sb.pop_front();
        check("abort_idx", dump_idx, e.idx);
        check("abort_data", dump_data, e.data);
      end
      next_cycle();
      k++;
    end
    check("abort_reach", dump_idx, 10);
    clr_n = 1'b0;
    #1;
    check("abort_valid", dump_valid, 0);
    check("abort_data0", dump_data, 0);
    check("abort_busy", busy, 1);
    check("abort_idx0", dump_idx, 0);
    sb.delete();
    for (int unsigned i = 0; i < NREG; i++) model[i] = '0;
    next_cycle();
    next_cycle();
    clr_n = 1'b1; dump_req = 1'b1; dump_ready = 1'b1;
    cnt = 0;
    while (busy && cnt < 100) begin
      check("reinit_valid", dump_valid, 0);
      next_cycle();
      dump_req = 1'b0;
      cnt++;
    end
    check("reinit_len", cnt, 31);
    check("reinit_idle_valid", dump_valid, 0);
    next_cycle();
    check("ignored_req", dump_valid, 0);
    rr1 = AW'(5); rr2 = AW'(8);
    #1;
    check("reinit_r5", rd1, model[5]);
    check("reinit_r8", rd2, model[8]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter DW, default 32: register data width in bits.
REQ-002 SHALL have parameter AW, default 5: address width; NREG = 2**AW registers.
REQ-003 SHALL have parameter OBS_IDX, default 1: register index driven onto obs_data.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port clr_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have ports rr1 and rr2, input, AW: read addresses.
REQ-007 SHALL have ports rd1 and rd2, output, DW: read data.
REQ-008 SHALL have port wr, input, AW: write address.
REQ-009 SHALL have port wd, input, DW: write data.
REQ-010 SHALL have port reg_write, input, 1: write enable.
REQ-011 SHALL have port obs_data, output, DW: continuous view of register OBS_IDX.
REQ-012 SHALL have port busy, output, 1: high while the initialisation sweep runs.
REQ-013 SHALL have port dump_req, input, 1: single-cycle request to stream all registers.
REQ-014 SHALL have ports dump_valid (output, 1), dump_ready (input, 1), dump_idx (output, AW) and dump_data (output, DW): dump stream.

Function
REQ-015 SHALL implement FSM states INIT, IDLE and DUMP.
REQ-016 INIT SHALL write 0 to one register per cycle, indices 1..NREG-1 ascending, then go to IDLE; the sweep lasts NREG-1 cycles.
REQ-017 While busy=1, rd1, rd2 and obs_data SHALL read 0, and reg_write SHALL be ignored.
REQ-018 Register 0 SHALL always read 0; writes to wr=0 SHALL be discarded.
REQ-019 Reads SHALL be combinational with zero-cycle latency.
REQ-020 When reg_write=1, wr!=0, busy=0 and rrN==wr, rdN SHALL return wd in the same cycle (write-through bypass). obs_data SHALL apply the same bypass when wr==OBS_IDX.
REQ-021 A write SHALL commit at the clk rising edge; a read in the following cycle returns the new value.
REQ-022 In IDLE, dump_req=1 SHALL move to DUMP with the dump index set to 0. In INIT or DUMP, dump_req SHALL be ignored.
REQ-023 In DUMP: dump_valid=1; dump_data = current contents of register dump_idx, with the bypass applied.
REQ-024 dump_idx SHALL advance only on a cycle where dump_valid and dump_ready are both 1.
REQ-025 The transfer at dump_idx=NREG-1 SHALL return the FSM to IDLE with dump_valid=0 on the next cycle.
REQ-026 While dump_ready=0, dump_idx SHALL hold and the FSM SHALL remain in DUMP; dump_data MAY change if that register is written.
REQ-027 Normal reads and writes SHALL continue unaffected during DUMP.

Reset
REQ-028 clr_n=0 SHALL force, asynchronously: state=INIT, sweep index=1, busy=1, dump_valid=0, dump_idx=0, dump_data=0.
REQ-029 Register array contents need no reset term; they become defined through the INIT sweep.
REQ-030 If reset is asserted mid-DUMP or mid-INIT, the dump SHALL abort and the sweep SHALL restart from index 1 after clr_n returns high.

Structure
REQ-031 The FSM state encoding (INIT/IDLE/DUMP) SHALL live in a shared package regfile_pkg, alongside the constant ZERO_REG=0.
REQ-032 One sub-module SHALL be used: regfile_bypass, the per-port read mux implementing the zero-register and bypass rules (REQ-018/020), instantiated three times (rd1, rd2, obs_data).
REQ-033 The dump path SHALL use its own bypass per REQ-023, either as a fourth instance or as equivalent local logic.

Verification
REQ-034 Reset test: release clr_n, AW=5 -> busy=1 for exactly 31 cycles; rd1=0 throughout; then busy=0 and every register reads 0.
REQ-035 Write/read test: write 70 to r1, 101 to r2, 343 to r3 -> next cycle rr1=2, rr2=3 gives rd1=101, rd2=343; obs_data=70.
REQ-036 Bypass test: reg_write=1, wr=5, wd=0xDEAD, rr1=5 in the same cycle -> rd1=0xDEAD combinationally.
REQ-037 Zero-register test: write 0xFFFF to r0 -> rd1 with rr1=0 reads 0, and obs_data is unchanged.
REQ-038 Dump test: issue dump_req with dump_ready toggling 1,0,1... -> 32 transfers with idx 0..31 in order, each data matching the register; write r7=9 before idx 7 is transferred -> idx 7 carries 9; then return to IDLE.
REQ-039 Abort test: pull clr_n low at dump_idx=10 -> dump_valid=0 immediately; after release, busy=1 and a dump_req during INIT is ignored.
